// File: rtl/pattern_serializer_if.sv
// Pattern-offer handshake between a stimulus source and the pattern serializer.
// The source drives valid/data/length; the serializer answers with ready.
interface pattern_serializer_if #(
    parameter int WIDTH = 8,
    parameter int LENW  = 4
);
    logic             pat_valid;
    logic [WIDTH-1:0] pat_data;
    logic [LENW-1:0]  pat_len;
    logic             pat_ready;

    modport master (
        output pat_valid,
        output pat_data,
        output pat_len,
        input  pat_ready
    );

    modport slave (
        input  pat_valid,
        input  pat_data,
        input  pat_len,
        output pat_ready
    );
endinterface

// File: rtl/pattern_serializer.sv
// Serial stimulus transmitter: accepts a pattern word, shifts it out MSB-first on 'a'
// one bit per enabled clock, then emits a fixed gap of zeros before the next pattern.
module pattern_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int LENW  = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    pattern_serializer_if.slave  pat,
    output logic                 a,
    output logic                 a_valid,
    output logic                 done,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    localparam int              GW      = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [LENW-1:0] WIDTH_L = LENW'(WIDTH);
    localparam logic [LENW-1:0] ONE_L   = LENW'(1);
    localparam logic [GW-1:0]   GAP_L   = GW'(GAP);
    localparam logic [GW-1:0]   GONE_L  = GW'(1);

    // Zero and over-long lengths both mean "send the full word".
    function automatic logic [LENW-1:0] eff_len(input logic [LENW-1:0] len);
        if ((len == {LENW{1'b0}}) || (len > WIDTH_L)) begin
            eff_len = WIDTH_L;
        end else begin
            eff_len = len;
        end
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [LENW-1:0]  cnt_r;
    logic [LENW-1:0]  cnt_nxt_s;
    logic [GW-1:0]    gap_r;
    logic [GW-1:0]    gap_nxt_s;
    logic             a_r;
    logic             a_nxt_s;
    logic             a_valid_r;
    logic             a_valid_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic [LENW-1:0]  len_eff_s;
    logic [WIDTH-1:0] shift_load_s;
    logic             pat_ready_s;

    assign pat_ready_s  = (state_r == ST_IDLE);
    assign len_eff_s    = eff_len(pat.pat_len);
    // Left-align so the first bit to send lands at the shift MSB.
    assign shift_load_s = pat.pat_data << (WIDTH_L - len_eff_s);

    // Next-state and next-output logic for the serializer FSM.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        cnt_nxt_s     = cnt_r;
        gap_nxt_s     = gap_r;
        a_nxt_s       = a_r;
        a_valid_nxt_s = 1'b0;
        done_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pat.pat_valid && pat_ready_s) begin
                    shift_nxt_s = shift_load_s;
                    cnt_nxt_s   = len_eff_s;
                    gap_nxt_s   = GAP_L;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (enable) begin
                    a_nxt_s       = shift_r[WIDTH-1];
                    shift_nxt_s   = {shift_r[WIDTH-2:0], 1'b0};
                    cnt_nxt_s     = cnt_r - ONE_L;
                    a_valid_nxt_s = 1'b1;
                    // A zero count can only come from an upset; treat it as the last bit.
                    if (cnt_r <= ONE_L) begin
                        done_nxt_s = 1'b1;
                        if (GAP == 0) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_GAP;
                        end
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (enable) begin
                    a_nxt_s   = 1'b0;
                    gap_nxt_s = gap_r - GONE_L;
                    if (gap_r <= GONE_L) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_GAP;
                    end
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                shift_nxt_s = {WIDTH{1'b0}};
                cnt_nxt_s   = {LENW{1'b0}};
                gap_nxt_s   = {GW{1'b0}};
                a_nxt_s     = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= {WIDTH{1'b0}};
            cnt_r     <= {LENW{1'b0}};
            gap_r     <= {GW{1'b0}};
            a_r       <= 1'b0;
            a_valid_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            shift_r   <= shift_nxt_s;
            cnt_r     <= cnt_nxt_s;
            gap_r     <= gap_nxt_s;
            a_r       <= a_nxt_s;
            a_valid_r <= a_valid_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign pat.pat_ready = pat_ready_s;
    assign a             = a_r;
    assign a_valid       = a_valid_r;
    assign done          = done_r;
    assign state         = state_r;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: directed patterns push expected serial
// bits into a queue; a negedge monitor pops and compares every valid bit.
module tb_pattern_serializer;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       a;
    logic       a_valid;
    logic       done;
    logic [1:0] state;

    pattern_serializer_if #(.WIDTH(8), .LENW(4)) pif ();

    pattern_serializer #(.WIDTH(8), .GAP(2), .LENW(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .pat     (pif),
        .a       (a),
        .a_valid (a_valid),
        .done    (done),
        .state   (state)
    );

    typedef struct packed {
        logic a;
        logic done;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every bit the DUT marks valid must match the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && a_valid) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_bit: got a=%0b with nothing expected", a);
            end else begin
                e = sb_q.pop_front();
                check("serial_a", 32'(a), 32'(e.a));
                check("serial_done", 32'(done), 32'(e.done));
            end
        end else if (reset_n && done) begin
            check("done_without_valid", 32'(done), 32'd0);
        end
    end

    task automatic push_bits(input logic [7:0] d, input int nbits);
        exp_t e;
        for (int i = nbits - 1; i >= 0; i--) begin
            e.a    = d[i];
            e.done = (i == 0);
            sb_q.push_back(e);
        end
    endtask

    task automatic run_pat(input string name, input logic [7:0] d, input logic [3:0] l,
                           input int nbits, input bit gated, input bit busy);
        int cyc;
        int wait_cnt;
        push_bits(d, nbits);
        wait_cnt = 0;
        while (!pif.pat_ready && wait_cnt < 50) begin
            @(posedge clock);
            #1;
            wait_cnt++;
        end
        check({name, "_ready_before"}, 32'(pif.pat_ready), 32'd1);
        pif.pat_valid = 1'b1;
        pif.pat_data  = d;
        pif.pat_len   = l;
        enable        = 1'b0;
        @(posedge clock);
        #1;
        check({name, "_state_shift"}, 32'(state), 32'd1);
        check({name, "_a_valid_accept"}, 32'(a_valid), 32'd0);
        if (busy) begin
            pif.pat_data = 8'hFF;
            pif.pat_len  = 4'd0;
        end else begin
            pif.pat_valid = 1'b0;
            pif.pat_data  = 8'($urandom);
            pif.pat_len   = 4'($urandom);
        end
        enable = 1'b1;
        cyc    = 0;
        while (!done && cyc < 64) begin
            @(posedge clock);
            #1;
            cyc++;
            check({name, "_ready_busy"}, 32'(pif.pat_ready), 32'd0);
            if (!done && gated) begin
                enable = ~enable;
            end
        end
        check({name, "_edges_to_done"}, 32'(cyc), gated ? 32'(2 * nbits - 1) : 32'(nbits));
        check({name, "_state_gap"}, 32'(state), 32'd2);
        enable = 1'b1;
        for (int g = 0; g < 2; g++) begin
            @(posedge clock);
            #1;
            check({name, "_gap_a"}, 32'(a), 32'd0);
            check({name, "_gap_valid"}, 32'(a_valid), 32'd0);
            check({name, "_gap_done"}, 32'(done), 32'd0);
        end
        check({name, "_state_idle"}, 32'(state), 32'd0);
        check({name, "_ready_after"}, 32'(pif.pat_ready), 32'd1);
    endtask

    initial begin
        reset_n       = 1'b1;
        enable        = 1'b0;
        pif.pat_valid = 1'b0;
        pif.pat_data  = 8'h00;
        pif.pat_len   = 4'd0;
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_a", 32'(a), 32'd0);
        check("reset_a_valid", 32'(a_valid), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ready", 32'(pif.pat_ready), 32'd1);
        check("reset_state", 32'(state), 32'd0);
        #10;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_pat("full", 8'b1011_0010, 4'd0, 8, 1'b0, 1'b0);
        run_pat("short", 8'hF2, 4'd3, 3, 1'b0, 1'b0);
        run_pat("gated", 8'hA5, 4'd8, 8, 1'b1, 1'b0);
        run_pat("busy", 8'h0F, 4'd8, 8, 1'b0, 1'b1);
        run_pat("busy_ff", 8'hFF, 4'd0, 8, 1'b0, 1'b0);
        run_pat("len_over", 8'h96, 4'd12, 8, 1'b0, 1'b0);

        // Reset after three bits of 8'hE1 (1,1,1 sent), then a fresh pattern.
        push_bits(8'hE1 >> 5, 3);
        sb_q[2].done = 1'b0;
        pif.pat_valid = 1'b1;
        pif.pat_data  = 8'hE1;
        pif.pat_len   = 4'd8;
        @(posedge clock);
        #1;
        pif.pat_valid = 1'b0;
        enable        = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset_a", 32'(a), 32'd0);
        check("midreset_a_valid", 32'(a_valid), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_ready", 32'(pif.pat_ready), 32'd1);
        check("midreset_state", 32'(state), 32'd0);
        check("midreset_bits_consumed", 32'(sb_q.size()), 32'd0);
        #9;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        run_pat("after_reset", 8'h3C, 4'd0, 8, 1'b0, 1'b0);

        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
